// File: rtl/cbfp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cbfp_pkg                                                                   |
// | Shared constants, exponent types and the saturating shift for cbfp_denorm. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cbfp_pkg;

  localparam int IN_WIDTH    = 11;
  localparam int OUT_WIDTH   = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int DATA_NUM    = 16;
  localparam int BLK_BEATS   = 4;
  localparam int EXP_DEPTH   = 4;
  localparam int SHIFT_POLE  = 12;

  // Wide enough that the largest left shift cannot overflow before saturation.
  localparam int EXT_WIDTH = IN_WIDTH + SHIFT_POLE;
  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = EXT_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = EXT_WIDTH'(-(1 << (OUT_WIDTH - 1)));

  typedef logic [SHIFT_WIDTH-1:0] exp_t;

  typedef struct packed {
    exp_t re;
    exp_t im;
  } exp_pair_t;

  function automatic logic signed [OUT_WIDTH-1:0] sat_shift(
    input logic signed [IN_WIDTH-1:0]  in_s,
    input logic signed [SHIFT_WIDTH:0] d
  );
    logic signed [EXT_WIDTH-1:0] ext;
    logic signed [EXT_WIDTH-1:0] sh;
    logic        [SHIFT_WIDTH:0] amt;
    ext = {{SHIFT_POLE{in_s[IN_WIDTH-1]}}, in_s};
    if (d < 0) begin
      amt = -d;
      sh  = ext >>> amt;
    end else begin
      amt = d;
      sh  = ext <<< amt;
    end
    if (sh > SAT_MAX) begin
      return SAT_MAX[OUT_WIDTH-1:0];
    end else if (sh < SAT_MIN) begin
      return SAT_MIN[OUT_WIDTH-1:0];
    end
    return sh[OUT_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cbfp_exp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cbfp_exp_fifo                                                              |
// | Synchronous FIFO of per-block exponent pairs with a combinational head.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cbfp_exp_fifo
  import cbfp_pkg::*;
#(
  parameter int DEPTH = EXP_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  exp_pair_t wdata_i,
  input  logic      pop_i,
  output exp_pair_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  exp_pair_t       mem_q [0:DEPTH-1];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cbfp_denorm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cbfp_denorm                                                                |
// | Re-applies per-block CBFP exponents to 16-sample beats, 1-cycle latency.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cbfp_denorm #(
  parameter int IN_WIDTH    = cbfp_pkg::IN_WIDTH,
  parameter int OUT_WIDTH   = cbfp_pkg::OUT_WIDTH,
  parameter int SHIFT_WIDTH = cbfp_pkg::SHIFT_WIDTH,
  parameter int DATA_NUM    = cbfp_pkg::DATA_NUM,
  parameter int BLK_BEATS   = cbfp_pkg::BLK_BEATS,
  parameter int EXP_DEPTH   = cbfp_pkg::EXP_DEPTH,
  parameter int SHIFT_POLE  = cbfp_pkg::SHIFT_POLE
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   din_valid,
  input  logic [IN_WIDTH-1:0]    din_real [0:DATA_NUM-1],
  input  logic [IN_WIDTH-1:0]    din_imag [0:DATA_NUM-1],
  input  logic                   exp_valid,
  input  logic [SHIFT_WIDTH-1:0] exp_re,
  input  logic [SHIFT_WIDTH-1:0] exp_im,
  output logic                   exp_ready,
  output logic                   valid_out,
  output logic                   blk_first,
  output logic [OUT_WIDTH-1:0]   dout_real [0:DATA_NUM-1],
  output logic [OUT_WIDTH-1:0]   dout_imag [0:DATA_NUM-1],
  output logic                   exp_underflow
);

  localparam int BEAT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BLK_BEATS - 1);
  localparam logic [SHIFT_WIDTH-1:0] POLE_EXP  = SHIFT_WIDTH'(SHIFT_POLE);

  cbfp_pkg::exp_pair_t fifo_wdata;
  cbfp_pkg::exp_pair_t fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                blk_start;

  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [SHIFT_WIDTH-1:0] act_re_q, act_im_q;
  logic [SHIFT_WIDTH-1:0] cur_re, cur_im;
  logic signed [SHIFT_WIDTH:0] d_re, d_im;
  logic                   valid_q, first_q, underflow_q;
  logic [OUT_WIDTH-1:0]   lane_re    [0:DATA_NUM-1];
  logic [OUT_WIDTH-1:0]   lane_im    [0:DATA_NUM-1];
  logic [OUT_WIDTH-1:0]   dout_re_q  [0:DATA_NUM-1];
  logic [OUT_WIDTH-1:0]   dout_im_q  [0:DATA_NUM-1];

  assign blk_start = din_valid && (beat_cnt_q == '0);

  always_comb begin
    fifo_wdata    = '0;
    fifo_wdata.re = exp_re;
    fifo_wdata.im = exp_im;
  end

  cbfp_exp_fifo #(
    .DEPTH (EXP_DEPTH)
  ) u_exp_fifo (
    .clk     (clk),
    .rst     (rstn),
    .push_i  (exp_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (blk_start),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign exp_ready = !fifo_full;

  // Beat 0 uses the FIFO head directly; later beats reuse the latched pair.
  always_comb begin
    cur_re = act_re_q;
    cur_im = act_im_q;
    if (blk_start) begin
      if (fifo_empty) begin
        cur_re = POLE_EXP;
        cur_im = POLE_EXP;
      end else begin
        cur_re = fifo_head.re;
        cur_im = fifo_head.im;
      end
    end
  end

  assign d_re = (SHIFT_WIDTH + 1)'(SHIFT_POLE) - {1'b0, cur_re};
  assign d_im = (SHIFT_WIDTH + 1)'(SHIFT_POLE) - {1'b0, cur_im};

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (din_valid) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
    assign lane_re[i] = cbfp_pkg::sat_shift($signed(din_real[i]), d_re);
    assign lane_im[i] = cbfp_pkg::sat_shift($signed(din_imag[i]), d_im);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      beat_cnt_q  <= '0;
      act_re_q    <= POLE_EXP;
      act_im_q    <= POLE_EXP;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      underflow_q <= 1'b0;
      dout_re_q   <= '{default: '0};
      dout_im_q   <= '{default: '0};
    end else begin
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= din_valid;
      first_q    <= blk_start;
      if (blk_start) begin
        act_re_q <= cur_re;
        act_im_q <= cur_im;
        if (fifo_empty) underflow_q <= 1'b1;
      end
      if (din_valid) begin
        dout_re_q <= lane_re;
        dout_im_q <= lane_im;
      end
    end
  end

  assign valid_out     = valid_q;
  assign blk_first     = first_q;
  assign exp_underflow = underflow_q;
  assign dout_real     = dout_re_q;
  assign dout_imag     = dout_im_q;

endmodule
`default_nettype wire

// File: tb/tb_cbfp_denorm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cbfp_denorm                                                             |
// | Directed table, hand sequences and random stimulus against a ref model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cbfp_denorm;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        din_valid;
  logic [10:0] din_real [0:N-1];
  logic [10:0] din_imag [0:N-1];
  logic        exp_valid;
  logic [4:0]  exp_re, exp_im;
  logic        exp_ready, valid_out, blk_first, exp_underflow;
  logic [15:0] dout_real [0:N-1];
  logic [15:0] dout_imag [0:N-1];

  always #5 clk = ~clk;

  cbfp_denorm dut (
    .clk           (clk),
    .rstn          (rstn),
    .din_valid     (din_valid),
    .din_real      (din_real),
    .din_imag      (din_imag),
    .exp_valid     (exp_valid),
    .exp_re        (exp_re),
    .exp_im        (exp_im),
    .exp_ready     (exp_ready),
    .valid_out     (valid_out),
    .blk_first     (blk_first),
    .dout_real     (dout_real),
    .dout_imag     (dout_imag),
    .exp_underflow (exp_underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: exponent queue plus block bookkeeping.
  typedef struct { int re; int im; } ep_t;
  ep_t q[$];
  int  m_beat, m_act_re, m_act_im;
  bit  m_valid, m_first, m_uf;
  int  m_dre [N];
  int  m_dim [N];

  typedef struct {
    bit ev; int ere; int eim;
    bit dv; int dre; int dim;
    bit xv; bit xf; int xre; int xim; bit xuf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit ev, int ere, int eim, bit dv, int dre, int dim,
                              bit xv, bit xf, int xre, int xim, bit xuf);
    vec_t v;
    v.ev = ev; v.ere = ere; v.eim = eim; v.dv = dv; v.dre = dre; v.dim = dim;
    v.xv = xv; v.xf = xf; v.xre = xre; v.xim = xim; v.xuf = xuf;
    return v;
  endfunction

  function automatic int ref_out(int x, int e);
    int d, k, v;
    d = 12 - e;
    if (d >= 0) begin
      v = x * (1 << d);
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
    end else begin
      k = -d;
      if (x >= 0) v = x / (1 << k);
      else        v = -(((-x) + (1 << k) - 1) / (1 << k));
    end
    return v;
  endfunction

  task automatic model_edge();
    bit  room;
    ep_t e;
    if (rstn) begin
      q.delete();
      m_beat = 0; m_valid = 0; m_first = 0; m_uf = 0;
      m_act_re = 12; m_act_im = 12;
      for (int i = 0; i < N; i++) begin m_dre[i] = 0; m_dim[i] = 0; end
    end else begin
      room    = (q.size() < 4);
      m_valid = din_valid;
      m_first = 0;
      if (din_valid) begin
        if (m_beat == 0) begin
          m_first = 1;
          if (q.size() > 0) begin
            e = q.pop_front();
            m_act_re = e.re; m_act_im = e.im;
          end else begin
            m_act_re = 12; m_act_im = 12; m_uf = 1;
          end
        end
        for (int i = 0; i < N; i++) begin
          m_dre[i] = ref_out(int'($signed(din_real[i])), m_act_re);
          m_dim[i] = ref_out(int'($signed(din_imag[i])), m_act_im);
        end
        m_beat = (m_beat + 1) % 4;
      end
      if (exp_valid && room) begin
        e.re = int'(exp_re); e.im = int'(exp_im);
        q.push_back(e);
      end
    end
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_lanes(string name, bit use_re, bit use_model, int req);
    int bad, a, r;
    bad = -1; a = 0; r = 0;
    for (int i = 0; i < N; i++) begin
      int av, rv;
      av = use_re ? int'($signed(dout_real[i])) : int'($signed(dout_imag[i]));
      rv = use_model ? (use_re ? m_dre[i] : m_dim[i]) : req;
      if (av != rv && bad < 0) begin bad = i; a = av; r = rv; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s lane=%0d actual=%0d required=%0d", name, bad, a, r);
    end
  endtask

  task automatic cmp_model(string tag);
    chk({tag, "/valid_out"}, int'(valid_out), int'(m_valid));
    chk({tag, "/blk_first"}, int'(blk_first), int'(m_first));
    chk({tag, "/underflow"}, int'(exp_underflow), int'(m_uf));
    chk({tag, "/exp_ready"}, int'(exp_ready), (q.size() < 4) ? 1 : 0);
    chk_lanes({tag, "/dout_real"}, 1'b1, 1'b1, 0);
    chk_lanes({tag, "/dout_imag"}, 1'b0, 1'b1, 0);
  endtask

  task automatic step(bit use_model, string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) cmp_model(tag);
  endtask

  task automatic set_data(bit dv, int re, int im);
    din_valid = dv;
    for (int i = 0; i < N; i++) begin
      din_real[i] = 11'(re);
      din_imag[i] = 11'(im);
    end
  endtask

  task automatic set_rand_data(bit dv);
    din_valid = dv;
    for (int i = 0; i < N; i++) begin
      din_real[i] = 11'($urandom);
      din_imag[i] = 11'($urandom);
    end
  endtask

  task automatic set_exp(bit ev, int re, int im);
    exp_valid = ev;
    exp_re    = 5'(re);
    exp_im    = 5'(im);
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    set_data(1'b0, 0, 0);
    set_exp(1'b0, 0, 0);
    step(1'b1, "reset");
    rstn = 1'b0;
  endtask

  initial begin
    int nfirst;
    rstn = 1'b1;
    set_data(1'b0, 0, 0);
    set_exp(1'b0, 0, 0);

    // Directed table: unity, left-saturate, right-floor, underflow, extremes.
    tbl.push_back(mk(1, 12, 12, 0, 0, 0,        0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 5, -7,       1, 1, 5, -7, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 1, 5, -7, 1, 0, 5, -7, 0));
    tbl.push_back(mk(1, 4, 10,  0, 0, 0,        0, 0, 5, -7, 0));
    tbl.push_back(mk(0, 0, 0,   1, 1023, -3,    1, 1, 32767, -12, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 1, 1023, -3, 1, 0, 32767, -12, 0));
    tbl.push_back(mk(1, 20, 31, 0, 0, 0,        0, 0, 32767, -12, 0));
    tbl.push_back(mk(0, 0, 0,   1, -1, 1000,    1, 1, -1, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 1, -1, 1000, 1, 0, -1, 0, 0));
    tbl.push_back(mk(0, 0, 0,   1, 300, -300,   1, 1, 300, -300, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 1, 300, -300, 1, 0, 300, -300, 1));
    tbl.push_back(mk(1, 11, 13, 0, 0, 0,        0, 0, 300, -300, 1));
    tbl.push_back(mk(0, 0, 0,   1, -1024, 1023, 1, 1, -2048, 511, 1));
    tbl.push_back(mk(1, 0, 12,  1, 7, -8,       1, 0, 14, -4, 1));
    tbl.push_back(mk(0, 0, 0,   1, 7, -8,       1, 0, 14, -4, 1));
    tbl.push_back(mk(0, 0, 0,   1, 7, -8,       1, 0, 14, -4, 1));
    tbl.push_back(mk(0, 0, 0,   1, -1024, -1024, 1, 1, -32768, -1024, 1));
    tbl.push_back(mk(0, 0, 0,   1, 1, -1,       1, 0, 4096, -1, 1));

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      string t;
      t = $sformatf("tbl%0d", r);
      set_exp(tbl[r].ev, tbl[r].ere, tbl[r].eim);
      set_data(tbl[r].dv, tbl[r].dre, tbl[r].dim);
      step(1'b0, t);
      chk({t, "/valid_out"}, int'(valid_out), int'(tbl[r].xv));
      chk({t, "/blk_first"}, int'(blk_first), int'(tbl[r].xf));
      chk({t, "/underflow"}, int'(exp_underflow), int'(tbl[r].xuf));
      chk({t, "/exp_ready"}, int'(exp_ready), 1);
      chk_lanes({t, "/dout_real"}, 1'b1, 1'b0, tbl[r].xre);
      chk_lanes({t, "/dout_imag"}, 1'b0, 1'b0, tbl[r].xim);
    end

    // FIFO fill: 5 pushes, the 5th dropped, then blocks drain exps 1..4 in order.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      set_exp(1, k, k);
      set_data(1'b0, 0, 0);
      step(1'b1, "fill");
      if (k == 3) chk("fill_ready_after3", int'(exp_ready), 1);
      if (k >= 4) chk("fill_ready_full", int'(exp_ready), 0);
    end
    set_exp(0, 0, 0);
    for (int b = 1; b <= 5; b++) begin
      for (int beat = 0; beat < 4; beat++) begin
        set_data(1'b1, 1, 1);
        step(1'b1, "drain");
        if (beat == 0) begin
          chk("drain_beat0_re", int'($signed(dout_real[0])), (b <= 4) ? (2048 >> (b - 1)) : 1);
          chk("drain_underflow", int'(exp_underflow), (b == 5) ? 1 : 0);
        end
      end
    end

    // Gapped valid: two exponents, eight valid beats among gaps.
    do_reset();
    set_data(1'b0, 0, 0);
    set_exp(1, 12, 12); step(1'b1, "gap_push");
    set_exp(1, 10, 10); step(1'b1, "gap_push");
    set_exp(0, 0, 0);
    nfirst = 0;
    for (int k = 0; k < 12; k++) begin
      set_rand_data((k % 3) != 1);
      step(1'b1, "gap");
      if (blk_first) nfirst++;
    end
    chk("gap_blocks", nfirst, 2);
    chk("gap_no_underflow", int'(exp_underflow), 0);

    // Reset mid-block discards the partial block and the queued exponent.
    set_exp(1, 8, 8); set_data(1'b0, 0, 0); step(1'b1, "mid_push");
    set_exp(1, 9, 9); set_data(1'b1, 2, 2); step(1'b1, "mid_beat");
    set_exp(0, 0, 0); set_data(1'b1, 2, 2); step(1'b1, "mid_beat");
    rstn = 1'b1; set_data(1'b1, 2, 2); step(1'b1, "mid_rst");
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_ready", int'(exp_ready), 1);
    rstn = 1'b0; set_data(1'b1, 3, -3); step(1'b1, "post_rst");
    chk("post_rst_first", int'(blk_first), 1);
    chk("post_rst_underflow", int'(exp_underflow), 1);
    chk("post_rst_re", int'($signed(dout_real[5])), 3);

    // Random traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rstn = ($urandom_range(0, 199) == 0);
      set_rand_data($urandom_range(0, 3) != 0);
      set_exp($urandom_range(0, 9) < 3, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      step(1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
